tt_pad_ctrl_cell: RTL and testbench
===================================

// Module: tt_pad_ctrl_cell
// PURPOSE
//  Parametrised tile-side pad-control cell: drives N_CH signal pads (A/OE/IE/SL/CS/PD/PU) plus the hclk pad pulls.
//  Per-channel pad mode is loaded over a serial config chain and applied atomically on commit.
//  Pad inputs are synchronised and edge-detected for user logic. Sits between a user tile and its hsig/hclk pad cells.
// PARAMETERS
//  N_CH         4   number of hsig channels (1..16)
//  SYNC_STAGES  2   input synchroniser depth (2..3)
//  (localparam) CFG_W=8 bits/channel; CHAIN_LEN=N_CH*CFG_W+2
// PORTS
//  clk          in   1       single clock, all flops rising edge
//  rst_n        in   1       asynchronous active-low reset
//  cfg_sdi      in   1       serial config data in
//  cfg_shift    in   1       shift enable: one bit per cycle
//  cfg_commit   in   1       single-cycle commit request
//  cfg_sdo      out  1       chain MSB, for daisy-chaining
//  cfg_ack      out  1       1-cycle pulse: commit accepted
//  cfg_err      out  1       sticky: commit rejected (bad bit count)
//  usr_out      in   N_CH    user output data
//  usr_oe       in   N_CH    user output enable (BIDIR mode only)
//  usr_in       out  N_CH    synchronised pad input
//  usr_in_rise  out  N_CH    1-cycle rising-edge pulse on usr_in
//  usr_in_fall  out  N_CH    1-cycle falling-edge pulse on usr_in
//  hclk_Y       in   1       hclk pad input (pass-through, unregistered, to usr logic via hclk_in)
//  hclk_in      out  1       = hclk_Y
//  hclk_PD/PU   out  1 each  hclk pad pull-down/pull-up
//  hsig_Y       in   N_CH    pad input
//  hsig_A       out  N_CH    pad output data
//  hsig_OE/IE/SL/CS/PD/PU out N_CH each  pad controls
// BEHAVIOUR
//  Config chain: shift reg SR[CHAIN_LEN-1:0]; on cfg_shift SR<={SR[CHAIN_LEN-2:0],cfg_sdi}; cfg_sdo=SR[MSB].
//  Layout: SR[1:0]={hclk_PU,hclk_PD}; ch i at SR[2+8i+:8]={INV,PU,PD,CS,SL,IE,MODE[1:0]}.
//  Bit counter CNT counts shifts since last accepted commit, saturates at CHAIN_LEN+1 (overrun).
//  Commit: if CNT==CHAIN_LEN -> SHADOW<=SR, CNT<=0, cfg_ack=1 next cycle, cfg_err<=0.
//    else SHADOW unchanged, CNT<=0, cfg_err<=1 (sticky until next accepted commit), no ack.
//  cfg_shift & cfg_commit same cycle: commit evaluated on pre-shift CNT/SR; shift ignored.
//  MODE: 00 DIS: OE=0,A=0 | 01 OUT: OE=1,A=usr_out^INV | 10 ODRAIN: A=0,OE=~(usr_out^INV)
//        11 BIDIR: OE=usr_oe, A=usr_out^INV.
//  hsig_A/OE registered: usr_out/usr_oe -> pad, 1 cycle latency. IE/SL/CS/PD/PU driven direct from SHADOW.
//  Input: hsig_Y -> SYNC_STAGES flops -> s; usr_in=(s^INV)&IE (latency SYNC_STAGES); rise/fall from usr_in
//    vs its previous value, asserted the same cycle usr_in changes. IE=0 forces usr_in=0 (may emit one fall).
//  New SHADOW takes effect on pads the cycle after ack pulses (OE/A) / same cycle as ack (static controls).
//  Reset (async, any time incl. mid-shift): SR=0, CNT=0, cfg_ack=0, cfg_err=0, sync/edge flops=0;
//    SHADOW: MODE=00, IE=0, SL=0, CS=0, PD=1, PU=0, INV=0; hclk_PD=1, hclk_PU=0;
//    outputs: hsig_A=0, hsig_OE=0, hsig_IE=0, hsig_PD=1, hsig_PU=0, usr_in*=0.
//  PD and PU both set in config is legal and passed through (pad-level concern).
// STRUCTURE
//  Package tt_pad_pkg: MODE enum (DIS/OUT/ODRAIN/BIDIR), CFG_W, per-field bit offsets, reset cfg constant.
//  Sub-module tt_pad_chan (one channel: output regs, synchroniser, edge detect), generate x N_CH.
//  Top holds SR, CNT, SHADOW, commit/ack/err logic and hclk pulls.
// TESTING
//  Reset: rst_n=0 -> all ports at reset values above; hsig_PD=all 1s, hclk_PD=1, cfg_err=0.
//  N_CH=4: shift 34 bits setting ch0 MODE=01, commit -> cfg_ack 1 cycle; usr_out[0]=1 -> hsig_A[0]=1,OE=1 next cycle.
//  Shift 33 bits, commit -> no ack, cfg_err=1, SHADOW unchanged; then 34 bits + commit -> ack, cfg_err=0.
//  ch1 MODE=10: usr_out[1]=0 -> OE=1,A=0; usr_out[1]=1 -> OE=0; INV=1 inverts both.
//  ch2 IE=1: hsig_Y[2] 0->1 -> usr_in[2]=1 and usr_in_rise[2]=1 exactly 2 cycles later (SYNC_STAGES=2), 1-cycle pulse.
//  Assert rst_n mid-shift (17 bits) then release -> CNT=0; commit without shifting -> cfg_err=1.

Source files
------------

// File: rtl/tt_pad_pkg.sv
// Shared types and constants for the tile pad-control cell.
// Holds the per-channel config byte layout, the pad modes and the reset configuration.
package tt_pad_pkg;

  localparam int unsigned CFG_W  = 8;
  localparam int unsigned HCLK_W = 2;
  localparam int unsigned MODE_W = 2;

  // Bit offsets inside one channel's config byte
  localparam int unsigned OFS_MODE = 0;
  localparam int unsigned OFS_IE   = 2;
  localparam int unsigned OFS_SL   = 3;
  localparam int unsigned OFS_CS   = 4;
  localparam int unsigned OFS_PD   = 5;
  localparam int unsigned OFS_PU   = 6;
  localparam int unsigned OFS_INV  = 7;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIS    = 2'b00,
    MODE_OUT    = 2'b01,
    MODE_ODRAIN = 2'b10,
    MODE_BIDIR  = 2'b11
  } pad_mode_e;

  typedef struct packed {
    logic      inv;
    logic      pu;
    logic      pd;
    logic      cs;
    logic      sl;
    logic      ie;
    pad_mode_e mode;
  } pad_cfg_t;

  typedef struct packed {
    logic pu;
    logic pd;
  } hclk_cfg_t;

  // Pads come out of reset disabled and pulled down
  localparam pad_cfg_t CFG_RST = '{
    inv: 1'b0, pu: 1'b0, pd: 1'b1, cs: 1'b0, sl: 1'b0, ie: 1'b0, mode: MODE_DIS
  };

  localparam hclk_cfg_t HCLK_RST = '{pu: 1'b0, pd: 1'b1};

endpackage

// File: rtl/tt_pad_chan.sv
// One hsig channel: registered pad output/enable per mode, input synchroniser and edge detect.
// The last synchroniser stage doubles as the usr_in register so usr_in is a flop output.
module tt_pad_chan
  import tt_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pad_mode_e mode,
  input  logic      inv,
  input  logic      ie,
  input  logic      usr_out,
  input  logic      usr_oe,
  input  logic      pad_y,
  output logic      pad_a,
  output logic      pad_oe,
  output logic      usr_in,
  output logic      usr_in_rise,
  output logic      usr_in_fall
);

  localparam int unsigned SYNC_W = SYNC_STAGES - 1;

  logic [SYNC_W-1:0] sync;
  logic              data;
  logic              a_d;
  logic              oe_d;
  logic              in_d;

  // Pad drive decode per mode
  always_comb begin
    a_d  = 1'b0;
    oe_d = 1'b0;
    data = usr_out ^ inv;
    case (mode)
      MODE_OUT: begin
        oe_d = 1'b1;
        a_d  = data;
      end
      MODE_ODRAIN: oe_d = ~data;
      MODE_BIDIR: begin
        oe_d = usr_oe;
        a_d  = data;
      end
      default: ;
    endcase
  end

  assign in_d = (sync[SYNC_W-1] ^ inv) & ie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_a  <= 1'b0;
      pad_oe <= 1'b0;
    end else begin
      pad_a  <= a_d;
      pad_oe <= oe_d;
    end
  end

  // Synchroniser plus edge pulses aligned with the usr_in change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= '0;
      usr_in      <= 1'b0;
      usr_in_rise <= 1'b0;
      usr_in_fall <= 1'b0;
    end else begin
      sync[0] <= pad_y;
      for (int k = 1; k < int'(SYNC_W); k++) begin
        sync[k] <= sync[k-1];
      end
      usr_in      <= in_d;
      usr_in_rise <= in_d & ~usr_in;
      usr_in_fall <= ~in_d & usr_in;
    end
  end

endmodule

// File: rtl/tt_pad_ctrl_cell.sv
// Tile-side pad control: serial config chain with counted, atomic commit into a shadow register
// that drives N_CH hsig pads and the hclk pad pulls.
module tt_pad_ctrl_cell
  import tt_pad_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_sdi,
  input  logic            cfg_shift,
  input  logic            cfg_commit,
  output logic            cfg_sdo,
  output logic            cfg_ack,
  output logic            cfg_err,
  input  logic [N_CH-1:0] usr_out,
  input  logic [N_CH-1:0] usr_oe,
  output logic [N_CH-1:0] usr_in,
  output logic [N_CH-1:0] usr_in_rise,
  output logic [N_CH-1:0] usr_in_fall,
  input  logic            hclk_Y,
  output logic            hclk_in,
  output logic            hclk_PD,
  output logic            hclk_PU,
  input  logic [N_CH-1:0] hsig_Y,
  output logic [N_CH-1:0] hsig_A,
  output logic [N_CH-1:0] hsig_OE,
  output logic [N_CH-1:0] hsig_IE,
  output logic [N_CH-1:0] hsig_SL,
  output logic [N_CH-1:0] hsig_CS,
  output logic [N_CH-1:0] hsig_PD,
  output logic [N_CH-1:0] hsig_PU
);

  localparam int unsigned CHAIN_LEN = N_CH * CFG_W + HCLK_W;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);

  localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]     CNT_SAT    = CNT_W'(CHAIN_LEN + 1);
  localparam logic [CHAIN_LEN-1:0] SHADOW_RST = {{N_CH{CFG_RST}}, HCLK_RST};

  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] sr_d;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] shadow_d;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ack_d;
  logic                 err_d;
  hclk_cfg_t            hclk_cfg;

  // Commit wins over a same-cycle shift and is judged on the pre-shift count
  always_comb begin
    sr_d     = sr;
    cnt_d    = cnt;
    shadow_d = shadow;
    ack_d    = 1'b0;
    err_d    = cfg_err;
    if (cfg_commit) begin
      cnt_d = '0;
      if (cnt == CNT_FULL) begin
        shadow_d = sr;
        ack_d    = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_shift) begin
      sr_d = {sr[CHAIN_LEN-2:0], cfg_sdi};
      if (cnt != CNT_SAT) begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      shadow  <= SHADOW_RST;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      sr      <= sr_d;
      cnt     <= cnt_d;
      shadow  <= shadow_d;
      cfg_ack <= ack_d;
      cfg_err <= err_d;
    end
  end

  assign cfg_sdo  = sr[CHAIN_LEN-1];
  assign hclk_in  = hclk_Y;
  assign hclk_cfg = hclk_cfg_t'(shadow[HCLK_W-1:0]);
  assign hclk_PD  = hclk_cfg.pd;
  assign hclk_PU  = hclk_cfg.pu;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    localparam int unsigned BASE = HCLK_W + CFG_W * i;

    pad_cfg_t c;

    assign c.mode = pad_mode_e'(shadow[BASE+OFS_MODE +: MODE_W]);
    assign c.ie   = shadow[BASE+OFS_IE];
    assign c.sl   = shadow[BASE+OFS_SL];
    assign c.cs   = shadow[BASE+OFS_CS];
    assign c.pd   = shadow[BASE+OFS_PD];
    assign c.pu   = shadow[BASE+OFS_PU];
    assign c.inv  = shadow[BASE+OFS_INV];

    // Static pad controls follow the shadow directly
    assign hsig_IE[i] = c.ie;
    assign hsig_SL[i] = c.sl;
    assign hsig_CS[i] = c.cs;
    assign hsig_PD[i] = c.pd;
    assign hsig_PU[i] = c.pu;

    tt_pad_chan #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (c.mode),
      .inv        (c.inv),
      .ie         (c.ie),
      .usr_out    (usr_out[i]),
      .usr_oe     (usr_oe[i]),
      .pad_y      (hsig_Y[i]),
      .pad_a      (hsig_A[i]),
      .pad_oe     (hsig_OE[i]),
      .usr_in     (usr_in[i]),
      .usr_in_rise(usr_in_rise[i]),
      .usr_in_fall(usr_in_fall[i])
    );
  end

endmodule

// File: tb/tb_tt_pad_ctrl_cell.sv
// Scoreboard bench for tt_pad_ctrl_cell (N_CH=4, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tt_pad_ctrl_cell;

  localparam int NC = 4;
  localparam int CL = NC * 8 + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_sdi, cfg_shift, cfg_commit;
  logic          cfg_sdo, cfg_ack, cfg_err;
  logic [NC-1:0] usr_out, usr_oe, usr_in, usr_in_rise, usr_in_fall;
  logic          hclk_Y, hclk_in, hclk_PD, hclk_PU;
  logic [NC-1:0] hsig_Y, hsig_A, hsig_OE, hsig_IE, hsig_SL, hsig_CS, hsig_PD, hsig_PU;

  always #5 clk = ~clk;

  tt_pad_ctrl_cell #(.N_CH(NC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_sdi(cfg_sdi), .cfg_shift(cfg_shift),
    .cfg_commit(cfg_commit), .cfg_sdo(cfg_sdo), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .usr_out(usr_out), .usr_oe(usr_oe), .usr_in(usr_in), .usr_in_rise(usr_in_rise),
    .usr_in_fall(usr_in_fall), .hclk_Y(hclk_Y), .hclk_in(hclk_in), .hclk_PD(hclk_PD),
    .hclk_PU(hclk_PU), .hsig_Y(hsig_Y), .hsig_A(hsig_A), .hsig_OE(hsig_OE),
    .hsig_IE(hsig_IE), .hsig_SL(hsig_SL), .hsig_CS(hsig_CS), .hsig_PD(hsig_PD),
    .hsig_PU(hsig_PU)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] obsq[$];
  int          passed = 0;
  int          total  = 0;
  logic [CL-1:0] shadow_m;

  localparam logic [CL-1:0] SH_RST = {8'h20, 8'h20, 8'h20, 8'h20, 2'b01};

  // Config byte: {INV,PU,PD,CS,SL,IE,MODE}
  function automatic logic [7:0] cb(input logic [1:0] mode, input logic ie, input logic sl,
                                    input logic cs, input logic pd, input logic pu, input logic inv);
    return {inv, pu, pd, cs, sl, ie, mode};
  endfunction

  function automatic logic [3:0] field_m(input logic [CL-1:0] sh, input int ofs);
    logic [3:0] v;
    for (int i = 0; i < NC; i++) v[i] = sh[2 + 8*i + ofs];
    return v;
  endfunction

  // Expected {OE,A} from the mode table
  function automatic logic [7:0] pads_m(input logic [CL-1:0] sh, input logic [3:0] uo,
                                        input logic [3:0] uoe);
    logic [3:0] oe, a;
    logic [7:0] b;
    logic       d;
    oe = '0;
    a  = '0;
    for (int i = 0; i < NC; i++) begin
      b = sh[2 + 8*i +: 8];
      d = uo[i] ^ b[7];
      case (b[1:0])
        2'b01: begin oe[i] = 1'b1; a[i] = d; end
        2'b10: oe[i] = ~d;
        2'b11: begin oe[i] = uoe[i]; a[i] = d; end
        default: ;
      endcase
    end
    return {oe, a};
  endfunction

  task automatic ex(input string n, input logic [31:0] v);
    sbq.push_back('{name: n, exp: v});
  endtask

  task automatic ob(input logic [31:0] v);
    obsq.push_back(v);
  endtask

  task automatic shift_bits(input logic [CL-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_sdi   = (i < CL) ? w[i] : 1'b0;
      cfg_shift = 1'b1;
      @(negedge clk);
    end
    cfg_shift = 1'b0;
    cfg_sdi   = 1'b0;
  endtask

  task automatic commit_pulse(input logic with_shift);
    cfg_commit = 1'b1;
    cfg_shift  = with_shift;
    cfg_sdi    = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    cfg_shift  = 1'b0;
    cfg_sdi    = 1'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [31:0] o;
    rst_n = 1'b0; cfg_sdi = 0; cfg_shift = 0; cfg_commit = 0;
    usr_out = '0; usr_oe = '0; hclk_Y = 0; hsig_Y = 4'hF;
    repeat (2) @(negedge clk);
    ex("rst_pads", 32'h00);   ob(32'({hsig_OE, hsig_A}));
    ex("rst_ie", 32'h0);      ob(32'(hsig_IE));
    ex("rst_sl_cs", 32'h00);  ob(32'({hsig_SL, hsig_CS}));
    ex("rst_pd", 32'hF);      ob(32'(hsig_PD));
    ex("rst_pu", 32'h0);      ob(32'(hsig_PU));
    ex("rst_hclk", 32'h1);    ob(32'({hclk_PU, hclk_PD}));
    ex("rst_cfg", 32'h0);     ob(32'({cfg_sdo, cfg_ack, cfg_err}));
    ex("rst_usr_in", 32'h0);  ob(32'({usr_in, usr_in_rise, usr_in_fall}));
    rst_n = 1'b1;
    hsig_Y = '0;
    shadow_m = SH_RST;
    repeat (3) @(negedge clk);
    hclk_Y = 1'b1;
    #1;
    ex("hclk_in", 32'h1);     ob(32'(hclk_in));
    hclk_Y = 1'b0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_commit_out();
    sb_t e;
    logic [31:0] o;
    logic [CL-1:0] w;
    logic [CL-1:0] old;
    w = {8'h20, 8'h20, 8'h20, cb(2'b01, 0, 1, 1, 0, 0, 0), 2'b10};
    shift_bits(w, CL);
    ex("sdo_full", 32'(w[CL-1])); ob(32'(cfg_sdo));
    commit_pulse(1'b0);
    old = shadow_m;
    shadow_m = w;
    ex("ack_on", 32'h1);          ob(32'(cfg_ack));
    ex("err_clr", 32'h0);         ob(32'(cfg_err));
    ex("hclk_new", 32'h2);        ob(32'({hclk_PU, hclk_PD}));
    ex("pd_new", 32'(field_m(w, 5))); ob(32'(hsig_PD));
    ex("sl_cs_new", 32'({field_m(w, 3), field_m(w, 4)})); ob(32'({hsig_SL, hsig_CS}));
    ex("pads_lag", 32'(pads_m(old, usr_out, usr_oe))); ob(32'({hsig_OE, hsig_A}));
    usr_out = 4'b0001;
    @(negedge clk);
    ex("ack_pulse", 32'h0);       ob(32'(cfg_ack));
    ex("pads_out", 32'(pads_m(shadow_m, usr_out, usr_oe))); ob(32'({hsig_OE, hsig_A}));
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_bad_count();
    sb_t e;
    logic [31:0] o;
    logic [CL-1:0] w;
    shift_bits(SH_RST, CL - 1);
    commit_pulse(1'b0);
    ex("short_ack", 32'h0);       ob(32'(cfg_ack));
    ex("short_err", 32'h1);       ob(32'(cfg_err));
    @(negedge clk);
    ex("err_sticky", 32'h1);      ob(32'(cfg_err));
    ex("short_keep", 32'(pads_m(shadow_m, usr_out, usr_oe))); ob(32'({hsig_OE, hsig_A}));
    ex("short_pd", 32'(field_m(shadow_m, 5))); ob(32'(hsig_PD));
    w = {cb(2'b11, 0, 0, 0, 1, 1, 0), cb(2'b00, 1, 0, 0, 0, 1, 0),
         cb(2'b10, 0, 0, 0, 1, 0, 0), cb(2'b01, 0, 0, 0, 0, 0, 0), 2'b01};
    shift_bits(w, CL);
    commit_pulse(1'b0);
    shadow_m = w;
    ex("good_ack", 32'h1);        ob(32'(cfg_ack));
    ex("good_err", 32'h0);        ob(32'(cfg_err));
    ex("good_pdpu", 32'({field_m(w, 6), field_m(w, 5)})); ob(32'({hsig_PU, hsig_PD}));
    ex("good_ie", 32'(field_m(w, 2))); ob(32'(hsig_IE));
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_odrain();
    sb_t e;
    logic [31:0] o;
    logic [7:0] pat [4];
    logic [CL-1:0] w;
    pat = '{8'h00, 8'h28, 8'hA0, 8'h08};
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        usr_out = pat[k][7:4];
        usr_oe  = pat[k][3:0];
        @(negedge clk);
        ex($sformatf("pads_p%0d_%0d", pass, k), 32'(pads_m(shadow_m, usr_out, usr_oe)));
        ob(32'({hsig_OE, hsig_A}));
      end
      if (pass == 0) begin
        w = shadow_m;
        w[2 + 8*1 + 7] = 1'b1;
        w[2 + 8*3 + 7] = 1'b1;
        shift_bits(w, CL);
        commit_pulse(1'b0);
        shadow_m = w;
        ex("inv_ack", 32'h1);     ob(32'(cfg_ack));
      end
    end
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_input_edge();
    sb_t e;
    logic [31:0] o;
    logic [CL-1:0] w;
    hsig_Y = 4'hF;
    ex("in_c1", 32'h000);
    ex("in_c2", 32'h440);
    ex("in_c3", 32'h400);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ob(32'({usr_in, usr_in_rise, usr_in_fall}));
    end
    hsig_Y = 4'h0;
    ex("in_c4", 32'h400);
    ex("in_c5", 32'h004);
    ex("in_c6", 32'h000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ob(32'({usr_in, usr_in_rise, usr_in_fall}));
    end
    hsig_Y = 4'hF;
    repeat (3) @(negedge clk);
    w = shadow_m;
    w[2 + 8*2 + 2] = 1'b0;
    shift_bits(w, CL);
    commit_pulse(1'b0);
    shadow_m = w;
    repeat (2) @(negedge clk);
    ex("ie_off", 32'h00);         ob(32'({usr_in, usr_in_rise}));
    hsig_Y = 4'h0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_reset_midshift();
    sb_t e;
    logic [31:0] o;
    for (int i = 0; i < 17; i++) begin
      cfg_sdi   = 1'b1;
      cfg_shift = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    shadow_m = SH_RST;
    ex("mid_pads", 32'h00);       ob(32'({hsig_OE, hsig_A}));
    ex("mid_pd", 32'hF);          ob(32'(hsig_PD));
    ex("mid_sdo", 32'h0);         ob(32'(cfg_sdo));
    cfg_shift = 1'b0;
    cfg_sdi   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    commit_pulse(1'b0);
    ex("mid_ack", 32'h0);         ob(32'(cfg_ack));
    ex("mid_err", 32'h1);         ob(32'(cfg_err));
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [31:0] o;
    logic [CL-1:0] w;
    w = {cb(2'b00, 0, 1, 0, 0, 1, 0), cb(2'b00, 0, 0, 1, 1, 0, 0),
         cb(2'b00, 1, 0, 0, 0, 0, 0), cb(2'b00, 0, 0, 0, 1, 1, 0), 2'b11};
    shift_bits(w, CL);
    commit_pulse(1'b1);
    shadow_m = w;
    ex("sc_ack", 32'h1);          ob(32'(cfg_ack));
    ex("sc_err", 32'h0);          ob(32'(cfg_err));
    ex("sc_static", 32'({field_m(w, 6), field_m(w, 5), field_m(w, 4), field_m(w, 3)}));
    ob(32'({hsig_PU, hsig_PD, hsig_CS, hsig_SL}));
    ex("sc_hclk", 32'h3);         ob(32'({hclk_PU, hclk_PD}));
    commit_pulse(1'b0);
    ex("b2b_ack", 32'h0);         ob(32'(cfg_ack));
    ex("b2b_err", 32'h1);         ob(32'(cfg_err));
    shift_bits(SH_RST, CL + 2);
    commit_pulse(1'b0);
    ex("ovr_ack", 32'h0);         ob(32'(cfg_ack));
    ex("ovr_err", 32'h1);         ob(32'(cfg_err));
    ex("ovr_keep", 32'(field_m(shadow_m, 5))); ob(32'(hsig_PD));
    shift_bits(SH_RST, CL);
    commit_pulse(1'b0);
    shadow_m = SH_RST;
    ex("fin_ack", 32'h1);         ob(32'(cfg_ack));
    ex("fin_err", 32'h0);         ob(32'(cfg_err));
    ex("fin_pd", 32'hF);          ob(32'(hsig_PD));
    while (sbq.size() != 0) begin
      e = sbq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e.exp) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.exp);
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit_out();
    test_bad_count();
    test_odrain();
    test_input_edge();
    test_reset_midshift();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
